// File: rtl/bounce_game_ctrl.sv
// -----------------------------------------------------------------------------
// bounce_game_ctrl
//   Game-flow controller for a bouncing-ball game: tracks the BCD score, the
//   balls remaining and the game phase (NEWGAME / PLAY / NEWBALL / OVER), and
//   produces the freeze and GAME OVER display enables.
//
// Parameters
//   LIVES        balls per game (1..3), loaded into ball at game start
//   TIMER_TICKS  refresh ticks of hold time in NEWBALL / OVER (1..255)
//
// Ports
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   refresh_tick  in   one-cycle frame-start pulse (paces the hold timer)
//   hit           in   one-cycle pulse, ball scored a point
//   miss          in   one-cycle pulse, ball lost
//   btn_jump      in   debounced level, rising edge starts play
//   btn_reset     in   debounced level, rising edge abandons the game
//   dig0 / dig1   out  score ones / tens digit, BCD, registered
//   ball          out  balls remaining, registered
//   graph_still   out  freeze ball and paddle motion (0 only in PLAY)
//   over_show     out  enable GAME OVER text (1 only in OVER)
//
// Build option
//   BOUNCE_SCORE_SAT_EN  defined: score saturates at 99; undefined: 99 wraps
//                        to 00.
// -----------------------------------------------------------------------------
module bounce_game_ctrl #(
    parameter int LIVES       = 3,
    parameter int TIMER_TICKS = 120
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       refresh_tick,
    input  logic       hit,
    input  logic       miss,
    input  logic       btn_jump,
    input  logic       btn_reset,
    output logic [3:0] dig0,
    output logic [3:0] dig1,
    output logic [1:0] ball,
    output logic       graph_still,
    output logic       over_show
);

    localparam logic [1:0] LIVES_B = 2'(LIVES);
    localparam logic [7:0] TICKS_B = 8'(TIMER_TICKS);

    typedef enum logic [1:0] {NEWGAME, PLAY, NEWBALL, OVER} state_t;

    state_t     state_q, state_d;
    logic [3:0] dig0_q, dig0_d, dig1_q, dig1_d;
    logic [1:0] ball_q, ball_d;
    logic [7:0] timer_q, timer_d;
    logic       graph_still_q, graph_still_d;
    logic       over_show_q, over_show_d;
    logic       jump_prev_q, rst_prev_q;
    logic       jump_ev, rst_ev;

    // Previous-value registers reset to 1 so a button held through reset
    // produces no event when reset is released.
    assign jump_ev = btn_jump  & ~jump_prev_q;
    assign rst_ev  = btn_reset & ~rst_prev_q;

    // One-point BCD increment. Using >= 9 keeps the digits BCD even if a
    // digit were ever out of range.
    function automatic logic [7:0] bcd_inc(input logic [3:0] d1, input logic [3:0] d0);
        logic [3:0] n1, n0;
        n1 = d1;
        n0 = d0;
`ifdef BOUNCE_SCORE_SAT_EN
        if (d1 == 4'd9 && d0 == 4'd9) return {d1, d0};
`endif
        if (d0 >= 4'd9) begin
            n0 = 4'd0;
            n1 = (d1 >= 4'd9) ? 4'd0 : 4'(d1 + 4'd1);
        end else begin
            n0 = 4'(d0 + 4'd1);
        end
        return {n1, n0};
    endfunction

    // ---------------- state register (and datapath registers) ---------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= NEWGAME;
            dig0_q        <= 4'd0;
            dig1_q        <= 4'd0;
            ball_q        <= LIVES_B;
            timer_q       <= 8'd0;
            graph_still_q <= 1'b1;
            over_show_q   <= 1'b0;
            jump_prev_q   <= 1'b1;
            rst_prev_q    <= 1'b1;
        end else begin
            state_q       <= state_d;
            dig0_q        <= dig0_d;
            dig1_q        <= dig1_d;
            ball_q        <= ball_d;
            timer_q       <= timer_d;
            graph_still_q <= graph_still_d;
            over_show_q   <= over_show_d;
            jump_prev_q   <= btn_jump;
            rst_prev_q    <= btn_reset;
        end
    end

    // ---------------- next-state logic ---------------------------------------
    always_comb begin
        state_d = state_q;
        if (rst_ev) begin
            state_d = NEWGAME;
        end else begin
            case (state_q)
                NEWGAME: if (jump_ev) state_d = PLAY;
                PLAY:    if (miss) state_d = (ball_q > 2'd1) ? NEWBALL : OVER;
                NEWBALL: if (jump_ev && timer_q == 8'd0) state_d = PLAY;
                OVER:    if (timer_q == 8'd0) state_d = NEWGAME;
                default: state_d = NEWGAME;
            endcase
        end
    end

    // ---------------- output / datapath logic --------------------------------
    always_comb begin
        dig0_d  = dig0_q;
        dig1_d  = dig1_q;
        ball_d  = ball_q;
        timer_d = timer_q;

        // Free-running hold timer: counts frames down, sticks at zero.
        if (refresh_tick && timer_q != 8'd0) timer_d = timer_q - 8'd1;

        if (rst_ev) begin
            dig0_d  = 4'd0;
            dig1_d  = 4'd0;
            ball_d  = LIVES_B;
            timer_d = 8'd0;
        end else begin
            case (state_q)
                PLAY: begin
                    // hit and miss together: both take effect.
                    if (hit) {dig1_d, dig0_d} = bcd_inc(dig1_q, dig0_q);
                    if (miss) begin
                        ball_d  = ball_q - 2'd1;
                        timer_d = TICKS_B;
                    end
                end
                OVER: begin
                    if (timer_q == 8'd0) begin
                        dig0_d = 4'd0;
                        dig1_d = 4'd0;
                        ball_d = LIVES_B;
                    end
                end
                default: ;
            endcase
        end

        // Registered flags follow the state being entered, so they line up
        // with state_q on the following cycle.
        graph_still_d = (state_d != PLAY);
        over_show_d   = (state_d == OVER);
    end

    assign dig0        = dig0_q;
    assign dig1        = dig1_q;
    assign ball        = ball_q;
    assign graph_still = graph_still_q;
    assign over_show   = over_show_q;

endmodule

// File: tb/tb_bounce_game_ctrl.sv
module tb_bounce_game_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       refresh_tick = 1'b0;
    logic       hit = 1'b0;
    logic       miss = 1'b0;
    logic       btn_jump = 1'b0;
    logic       btn_reset = 1'b0;
    logic [3:0] dig0, dig1;
    logic [1:0] ball;
    logic       graph_still, over_show;

    int errors = 0;
    int checks = 0;

    bounce_game_ctrl #(.LIVES(3), .TIMER_TICKS(120)) dut (
        .clk(clk), .rst_n(rst_n), .refresh_tick(refresh_tick),
        .hit(hit), .miss(miss), .btn_jump(btn_jump), .btn_reset(btn_reset),
        .dig0(dig0), .dig1(dig1), .ball(ball),
        .graph_still(graph_still), .over_show(over_show)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_jump();
        btn_jump = 1'b1; step(); btn_jump = 1'b0; step();
    endtask

    task automatic press_reset();
        btn_reset = 1'b1; step(); btn_reset = 1'b0; step();
    endtask

    task automatic do_hits(input int n);
        repeat (n) begin hit = 1'b1; step(); hit = 1'b0; end
    endtask

    task automatic do_miss();
        miss = 1'b1; step(); miss = 1'b0;
    endtask

    task automatic refresh(input int n);
        repeat (n) begin refresh_tick = 1'b1; step(); refresh_tick = 1'b0; end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        btn_jump = 1'b1;            // held through reset: must not start play
        btn_reset = 1'b1;
        step(2);
        checks++; if ({dig1, dig0} !== 8'h00) begin errors++; $display("FAIL reset_score: got %h want 00", {dig1, dig0}); end
        checks++; if (ball !== 2'd3) begin errors++; $display("FAIL reset_ball: got %0d want 3", ball); end
        checks++; if ({graph_still, over_show} !== 2'b10) begin errors++; $display("FAIL reset_flags: got %b want 10", {graph_still, over_show}); end
        checks++; if (dut.timer_q !== 8'd0) begin errors++; $display("FAIL reset_timer: got %0d want 0", dut.timer_q); end
        rst_n = 1'b1;
        step(3);
        checks++; if (graph_still !== 1'b1) begin errors++; $display("FAIL held_button_no_event: graph_still got %b want 1", graph_still); end
        btn_jump = 1'b0; btn_reset = 1'b0;
        step();
    endtask

    task automatic test_outside_play_ignored();
        do_hits(2); do_miss(); step();
        checks++; if ({dig1, dig0} !== 8'h00 || ball !== 2'd3) begin errors++; $display("FAIL newgame_ignore: got score %h ball %0d want 00 3", {dig1, dig0}, ball); end
    endtask

    task automatic test_score();
        press_jump();
        checks++; if (graph_still !== 1'b0) begin errors++; $display("FAIL play_entry: graph_still got %b want 0", graph_still); end
        do_hits(12);
        checks++; if ({dig1, dig0} !== 8'h12) begin errors++; $display("FAIL score_12: got %h want 12", {dig1, dig0}); end
        checks++; if (graph_still !== 1'b0 || over_show !== 1'b0) begin errors++; $display("FAIL play_flags: got %b%b want 00", graph_still, over_show); end
    endtask

    task automatic test_miss_newball();
        do_miss();
        checks++; if (ball !== 2'd2) begin errors++; $display("FAIL miss_ball: got %0d want 2", ball); end
        checks++; if ({graph_still, over_show} !== 2'b10) begin errors++; $display("FAIL newball_flags: got %b want 10", {graph_still, over_show}); end
        checks++; if (dut.timer_q !== 8'd120) begin errors++; $display("FAIL timer_load: got %0d want 120", dut.timer_q); end
        do_hits(1);
        checks++; if ({dig1, dig0} !== 8'h12) begin errors++; $display("FAIL newball_hit_ignored: got %h want 12", {dig1, dig0}); end
        refresh(119);
        press_jump();
        checks++; if (graph_still !== 1'b1) begin errors++; $display("FAIL early_jump: graph_still got %b want 1", graph_still); end
        refresh(1);
        refresh(3);                 // extra ticks at zero: timer must not wrap
        checks++; if (dut.timer_q !== 8'd0) begin errors++; $display("FAIL timer_nowrap: got %0d want 0", dut.timer_q); end
        press_jump();
        checks++; if (graph_still !== 1'b0) begin errors++; $display("FAIL late_jump: graph_still got %b want 0", graph_still); end
    endtask

    task automatic test_game_over();
        do_miss();                  // ball 2 -> 1
        refresh(120);
        press_jump();
        do_miss();                  // ball 1 -> 0
        checks++; if (ball !== 2'd0) begin errors++; $display("FAIL over_ball: got %0d want 0", ball); end
        checks++; if ({graph_still, over_show} !== 2'b11) begin errors++; $display("FAIL over_flags: got %b want 11", {graph_still, over_show}); end
        press_jump();
        refresh(119);
        checks++; if (over_show !== 1'b1) begin errors++; $display("FAIL over_hold: over_show got %b want 1", over_show); end
        refresh(1);
        step();
        checks++; if (over_show !== 1'b0 || graph_still !== 1'b1) begin errors++; $display("FAIL over_exit_flags: got %b%b want 10", graph_still, over_show); end
        checks++; if (ball !== 2'd3 || {dig1, dig0} !== 8'h00) begin errors++; $display("FAIL newgame_restore: got ball %0d score %h want 3 00", ball, {dig1, dig0}); end
    endtask

    task automatic test_hit_miss_same();
        press_reset();
        press_jump();
        do_hits(5);
        do_miss();
        refresh(120);
        press_jump();
        hit = 1'b1; miss = 1'b1; step(); hit = 1'b0; miss = 1'b0;
        checks++; if ({dig1, dig0} !== 8'h06) begin errors++; $display("FAIL same_cycle_score: got %h want 06", {dig1, dig0}); end
        checks++; if (ball !== 2'd1 || {graph_still, over_show} !== 2'b10) begin errors++; $display("FAIL same_cycle_ball: got ball %0d flags %b want 1 10", ball, {graph_still, over_show}); end
    endtask

    task automatic test_score_limit();
        logic [7:0] exp_score;
        int s;
        press_reset();
        press_jump();
        for (int i = 1; i <= 99; i++) begin
            do_hits(1);
            if (i % 9 == 0) begin
                s = i;
                exp_score = {4'(s / 10), 4'(s % 10)};
                checks++; if ({dig1, dig0} !== exp_score) begin errors++; $display("FAIL bcd_count_%0d: got %h want %h", i, {dig1, dig0}, exp_score); end
            end
        end
        do_hits(1);
`ifdef BOUNCE_SCORE_SAT_EN
        exp_score = 8'h99;
`else
        exp_score = 8'h00;
`endif
        checks++; if ({dig1, dig0} !== exp_score) begin errors++; $display("FAIL score_99_hit: got %h want %h", {dig1, dig0}, exp_score); end
    endtask

    task automatic test_btn_reset();
        press_reset();
        press_jump();
        do_hits(37);
        do_miss();
        refresh(70);
        checks++; if (dut.timer_q !== 8'd50 || {dig1, dig0} !== 8'h37) begin errors++; $display("FAIL pre_reset: got timer %0d score %h want 50 37", dut.timer_q, {dig1, dig0}); end
        btn_reset = 1'b1; btn_jump = 1'b1; hit = 1'b1; miss = 1'b1;
        step();
        btn_reset = 1'b0; btn_jump = 1'b0; hit = 1'b0; miss = 1'b0;
        checks++; if ({dig1, dig0} !== 8'h00 || ball !== 2'd3) begin errors++; $display("FAIL btn_reset_vals: got score %h ball %0d want 00 3", {dig1, dig0}, ball); end
        checks++; if (dut.timer_q !== 8'd0 || {graph_still, over_show} !== 2'b10) begin errors++; $display("FAIL btn_reset_state: got timer %0d flags %b want 0 10", dut.timer_q, {graph_still, over_show}); end
    endtask

    task automatic test_async_reset();
        press_jump();
        do_hits(4);
        hit = 1'b1;
        #3 rst_n = 1'b0;            // mid-cycle, away from any edge
        #1;
        checks++; if ({dig1, dig0} !== 8'h00 || ball !== 2'd3 || graph_still !== 1'b1) begin errors++; $display("FAIL async_reset: got score %h ball %0d gs %b want 00 3 1", {dig1, dig0}, ball, graph_still); end
        step(2);
        hit = 1'b0;
        rst_n = 1'b1;
        step(2);
        checks++; if ({dig1, dig0} !== 8'h00 || graph_still !== 1'b1) begin errors++; $display("FAIL post_async_reset: got score %h gs %b want 00 1", {dig1, dig0}, graph_still); end
    endtask

    initial begin
        test_reset();
        test_outside_play_ignored();
        test_score();
        test_miss_newball();
        test_game_over();
        test_hit_miss_same();
        test_score_limit();
        test_btn_reset();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bounce_game_ctrl.md
BOUNCE_GAME_CTRL -- requirements
Module: bounce_game_ctrl

Interface
REQ-001 Parameter LIVES, default 3: balls per game (1..3); loaded into ball at game start.
REQ-002 Parameter TIMER_TICKS, default 120: refresh ticks of hold time in NEWBALL/OVER (1..255; 120 = 2 s at 60 Hz).
REQ-003 clk  in  1  system clock; sole clock domain.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 refresh_tick  in  1  one-cycle frame-start pulse.
REQ-006 hit  in  1  one-cycle pulse: ball scored a point.
REQ-007 miss  in  1  one-cycle pulse: ball lost.
REQ-008 btn_jump  in  1  synchronized, debounced level (T18).
REQ-009 btn_reset  in  1  synchronized, debounced level (T17).
REQ-010 dig0  out  4  score ones digit, BCD, registered.
REQ-011 dig1  out  4  score tens digit, BCD, registered.
REQ-012 ball  out  2  balls remaining, registered.
REQ-013 graph_still  out  1  freeze ball and paddle motion, registered.
REQ-014 over_show  out  1  enable the GAME OVER text, registered.

Function
REQ-015 Each button shall be edge-detected by a registered previous value; one rising edge gives exactly one event.
REQ-016 The FSM shall have four states: NEWGAME, PLAY, NEWBALL, OVER.
REQ-017 NEWGAME: graph_still=1, score held at 00, ball=LIVES; btn_jump edge -> PLAY next cycle.
REQ-018 PLAY: graph_still=0; hit increments the score one cycle later.
REQ-019 PLAY miss with ball>1: ball decrements, timer loads TIMER_TICKS, go to NEWBALL.
REQ-020 PLAY miss with ball==1: ball becomes 0, timer loads TIMER_TICKS, go to OVER.
REQ-021 If hit and miss are asserted in the same PLAY cycle, both shall be applied: score increments and the miss transition is taken.
REQ-022 NEWBALL: graph_still=1; btn_jump edge shall be ignored until timer==0; btn_jump edge at timer==0 -> PLAY.
REQ-023 OVER: graph_still=1, over_show=1; timer==0 -> NEWGAME, with score cleared to 00 and ball=LIVES on entry.
REQ-024 Timer: 8-bit down-counter; decrements only on refresh_tick while nonzero; it shall not wrap below 0.
REQ-025 btn_reset edge in any state: next cycle state=NEWGAME, score=00, ball=LIVES, timer=0, over_show=0; it overrides hit, miss and btn_jump in the same cycle.
REQ-026 Score increment: dig0 9->0 carries into dig1; dig0 and dig1 shall never hold a non-BCD value.
REQ-027 hit and miss shall be ignored outside PLAY.
REQ-028 over_show shall be 1 only in OVER; graph_still shall be 0 only in PLAY.

Reset
REQ-029 While rst_n=0: state=NEWGAME, dig0=0, dig1=0, ball=LIVES, graph_still=1, over_show=0, timer=0.
REQ-030 Button previous-value registers shall reset to 1, so a button held through reset does not generate an event.
REQ-031 Reset asserted mid-game shall abandon the game immediately; no partial score update shall survive.

Configuration
REQ-032 Macro BOUNCE_SCORE_SAT_EN defined: a hit at score 99 shall leave the score at 99.
REQ-033 Macro BOUNCE_SCORE_SAT_EN undefined: a hit at score 99 shall wrap the score to 00.
REQ-034 With the macro undefined, ball, FSM and timer behaviour shall be identical to the defined case.

Verification
REQ-035 Release reset, btn_jump edge, 12 hit pulses -> state PLAY, dig1=1, dig0=2, graph_still=0.
REQ-036 In PLAY with ball=3, miss -> ball=2, NEWBALL; btn_jump edge before the 120th refresh_tick is ignored; btn_jump edge after the 120th refresh_tick -> PLAY.
REQ-037 Three misses with the timer expired between them -> ball=0, over_show=1; after 120 refresh_ticks -> NEWGAME, ball=3, score 00.
REQ-038 Score 99 plus one hit -> 99 with BOUNCE_SCORE_SAT_EN defined; 00 with it undefined.
REQ-039 hit and miss in the same cycle at score 05, ball=2 -> score 06, ball=1, NEWBALL.
REQ-040 btn_reset edge in NEWBALL at timer=50 with score 37 -> NEWGAME next cycle, score 00, ball=3, timer=0.
